// File: rtl/starfield_ctrl.sv
// starfield_ctrl: steps the starfield LFSR during the visible area and adds extra steps each frame.
// Optional periodic LFSR seed reload is enabled by defining STARFIELD_CTRL_RELOAD_EN.
module starfield_ctrl #(
    parameter logic [31:0] SEED          = 32'h0000_0001,
    parameter int          RELOAD_FRAMES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hpos,
    input  logic [15:0] vpos,
    input  logic [3:0]  speed,
    input  logic        pause,
    output logic        lfsr_enable,
    output logic        lfsr_load,
    output logic [31:0] lfsr_seed,
    output logic [15:0] frame_cnt,
    output logic        busy
);

`ifdef STARFIELD_CTRL_RELOAD_EN
    typedef enum logic [1:0] {RUN, ADVANCE, LOAD} state_t;
`else
    typedef enum logic [1:0] {RUN, ADVANCE} state_t;
`endif

    if (RELOAD_FRAMES < 1) begin : g_reload_check
        $error("RELOAD_FRAMES must be at least 1");
    end

    state_t      state, state_next;
    logic        vb_q;
    logic [3:0]  step_cnt;
    logic        accept;
    logic        reload_hit;

    assign accept = (state == RUN) && vpos[15] && !vb_q && !pause;

`ifdef STARFIELD_CTRL_RELOAD_EN
    logic [31:0] reload_cnt;

    assign reload_hit = (reload_cnt == 32'(RELOAD_FRAMES - 1));

    // reload counter: frames accepted since the last seed reload
    always_ff @(posedge clk) begin
        if (reset)
            reload_cnt <= '0;
        else if (accept)
            reload_cnt <= reload_hit ? '0 : reload_cnt + 32'd1;
    end
`else
    assign reload_hit = 1'b0;
`endif

    // state register plus the blanking edge detector and per-frame counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            vb_q      <= 1'b1;
            step_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            vb_q      <= vpos[15];
            step_cnt  <= (state == RUN && state_next == ADVANCE) ? speed :
                         (state == ADVANCE) ? step_cnt - 4'd1 : step_cnt;
            frame_cnt <= accept ? frame_cnt + 16'd1 : frame_cnt;
        end
    end

    // next state: an accepted vblank entry starts a reload or an advance burst
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
`ifdef STARFIELD_CTRL_RELOAD_EN
                if (accept)
                    state_next = reload_hit ? LOAD : (speed != 4'd0) ? ADVANCE : RUN;
`else
                if (accept && !reload_hit && speed != 4'd0)
                    state_next = ADVANCE;
`endif
            end
            ADVANCE: state_next = (step_cnt == 4'd1) ? RUN : ADVANCE;
            default: state_next = RUN;
        endcase
    end

    // outputs: step only in the visible area while running, every cycle while advancing
    always_comb begin
        lfsr_enable = (state == ADVANCE) ? 1'b1 :
                      (state == RUN) ? (!hpos[15] && !vpos[15] && !pause) : 1'b0;
`ifdef STARFIELD_CTRL_RELOAD_EN
        lfsr_load   = (state == LOAD);
`else
        lfsr_load   = 1'b0;
`endif
        lfsr_seed   = SEED;
        busy        = (state != RUN);
    end

endmodule

// File: tb/tb_starfield_ctrl.sv
// tb_starfield_ctrl: directed self-checking bench for starfield_ctrl.
module tb_starfield_ctrl;
    localparam logic [31:0] SEED = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hpos = 16'd0;
    logic [15:0] vpos = 16'd0;
    logic [3:0]  speed = 4'd0;
    logic        pause = 1'b0;
    logic        lfsr_enable, lfsr_load, busy;
    logic [31:0] lfsr_seed;
    logic [15:0] frame_cnt;
    int checks = 0;
    int errors = 0;

    starfield_ctrl #(.SEED(SEED), .RELOAD_FRAMES(4)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .speed(speed), .pause(pause),
        .lfsr_enable(lfsr_enable), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; vpos = 16'hFFE0; hpos = 16'd5; speed = 4'd3; pause = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame got %0d exp 0", frame_cnt); end
        checks++; if (lfsr_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", lfsr_load); end
        checks++; if (lfsr_seed !== SEED) begin errors++; $display("FAIL reset_seed got %h exp %h", lfsr_seed, SEED); end
        tick();
        checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL no_spurious_entry busy %b frame %0d exp 0 0", busy, frame_cnt); end
    endtask

    task automatic test_visible();
        vpos = 16'd5; hpos = 16'd5; pause = 1'b0; speed = 4'd0;
        #1;
        checks++; if (lfsr_enable !== 1'b1) begin errors++; $display("FAIL visible_en got %b exp 1", lfsr_enable); end
        hpos = 16'hFFF0;
        #1;
        checks++; if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL hblank_en got %b exp 0", lfsr_enable); end
        hpos = 16'd5; vpos = 16'hFFF0;
        #1;
        checks++; if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL vblank_en got %b exp 0", lfsr_enable); end
        vpos = 16'd5;
        tick();
    endtask

    task automatic test_advance();
        vpos = 16'd479; hpos = 16'd5; speed = 4'd3;
        tick();
        vpos = 16'hFFE0;
        #1;
        checks++; if (busy !== 1'b0 || lfsr_enable !== 1'b0) begin errors++; $display("FAIL adv_entry busy %b en %b exp 0 0", busy, lfsr_enable); end
        tick();
        speed = 4'd7;
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL adv_frame got %0d exp 1", frame_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (lfsr_enable !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL adv_cycle%0d en %b busy %b exp 1 1", i, lfsr_enable, busy); end
            if (i == 1) pause = 1'b1;
            tick();
        end
        checks++; if (lfsr_enable !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL adv_end en %b busy %b exp 0 0", lfsr_enable, busy); end
        pause = 1'b0; vpos = 16'd0;
        tick();
        checks++; if (lfsr_enable !== 1'b1 || frame_cnt !== 16'd1) begin errors++; $display("FAIL adv_after en %b frame %0d exp 1 1", lfsr_enable, frame_cnt); end
    endtask

    task automatic test_zero_speed();
        speed = 4'd0; vpos = 16'hFFE0;
        tick();
        checks++; if (busy !== 1'b0 || lfsr_enable !== 1'b0 || frame_cnt !== 16'd2) begin errors++; $display("FAIL zero_speed busy %b en %b frame %0d exp 0 0 2", busy, lfsr_enable, frame_cnt); end
        tick();
        checks++; if (busy !== 1'b0 || lfsr_enable !== 1'b0) begin errors++; $display("FAIL zero_speed_hold busy %b en %b exp 0 0", busy, lfsr_enable); end
        vpos = 16'd0;
        tick();
    endtask

    task automatic test_pause();
        pause = 1'b1; speed = 4'd3; vpos = 16'd100;
        #1;
        checks++; if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL pause_visible got %b exp 0", lfsr_enable); end
        vpos = 16'hFFE0;
        tick();
        checks++; if (busy !== 1'b0 || lfsr_enable !== 1'b0 || frame_cnt !== 16'd2) begin errors++; $display("FAIL pause_entry busy %b en %b frame %0d exp 0 0 2", busy, lfsr_enable, frame_cnt); end
        vpos = 16'd0;
        tick();
        checks++; if (lfsr_enable !== 1'b0 || frame_cnt !== 16'd2) begin errors++; $display("FAIL pause_frame en %b frame %0d exp 0 2", lfsr_enable, frame_cnt); end
        pause = 1'b0;
        #1;
        checks++; if (lfsr_enable !== 1'b1) begin errors++; $display("FAIL unpause_en got %b exp 1", lfsr_enable); end
    endtask

    task automatic test_ignored_entry();
        int n;
        speed = 4'd4; vpos = 16'hFFE0;
        tick();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1 && lfsr_enable === 1'b1) n++;
            vpos = (i == 0) ? 16'd0 : 16'hFFE0;
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL ignored_entry_cycles got %0d exp 4", n); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL ignored_entry_frame got %0d exp 3", frame_cnt); end
        vpos = 16'd0;
        tick();
    endtask

    task automatic test_max_speed();
        int n;
        speed = 4'd15; vpos = 16'hFFE0;
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1) n++;
            tick();
        end
        checks++; if (n !== 15) begin errors++; $display("FAIL max_speed_cycles got %0d exp 15", n); end
        checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL max_speed_frame got %0d exp 4", frame_cnt); end
        vpos = 16'd0;
        tick();
    endtask

    task automatic test_reset_abort();
        speed = 4'd5; vpos = 16'hFFE0;
        tick();
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre busy got %b exp 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0; vpos = 16'd5; hpos = 16'd5;
        #1;
        checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0 || lfsr_load !== 1'b0) begin errors++; $display("FAIL abort_post busy %b frame %0d load %b exp 0 0 0", busy, frame_cnt, lfsr_load); end
        checks++; if (lfsr_enable !== 1'b1) begin errors++; $display("FAIL abort_en got %b exp 1", lfsr_enable); end
        hpos = 16'hFFF0;
        #1;
        checks++; if (lfsr_enable !== 1'b0) begin errors++; $display("FAIL abort_hblank got %b exp 0", lfsr_enable); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stay_run got %b exp 0", busy); end
        hpos = 16'd5;
    endtask

`ifdef STARFIELD_CTRL_RELOAD_EN
    task automatic test_reload();
        int n;
        reset = 1'b1; vpos = 16'd0; speed = 4'd2; pause = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        for (int f = 1; f <= 5; f++) begin
            vpos = 16'hFFE0;
            tick();
            if (f == 4) begin
                checks++; if (lfsr_load !== 1'b1 || lfsr_enable !== 1'b0 || lfsr_seed !== SEED) begin errors++; $display("FAIL reload_load load %b en %b seed %h exp 1 0 %h", lfsr_load, lfsr_enable, lfsr_seed, SEED); end
                tick();
                checks++; if (lfsr_load !== 1'b0 || busy !== 1'b0 || lfsr_enable !== 1'b0) begin errors++; $display("FAIL reload_after load %b busy %b en %b exp 0 0 0", lfsr_load, busy, lfsr_enable); end
            end else begin
                n = 0;
                for (int i = 0; i < 4; i++) begin
                    if (busy === 1'b1 && lfsr_enable === 1'b1) n++;
                    if (lfsr_load !== 1'b0) n = 99;
                    tick();
                end
                checks++; if (n !== 2) begin errors++; $display("FAIL reload_frame%0d adv got %0d exp 2", f, n); end
            end
            checks++; if (frame_cnt !== 16'(f)) begin errors++; $display("FAIL reload_count%0d got %0d exp %0d", f, frame_cnt, f); end
            vpos = 16'd0;
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_visible();
        test_advance();
        test_zero_speed();
        test_pause();
        test_ignored_entry();
        test_max_speed();
        test_reset_abort();
`ifdef STARFIELD_CTRL_RELOAD_EN
        test_reload();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
